// File: rtl/nes_joypad_serializer.sv
// NES controller-port serializer: strobe reloads per-port shift registers, falling read clocks shift them out.
// Optional turbo auto-fire on A/B is compiled in with `define JOYPAD_TURBO_EN.
module nes_joypad_serializer #(
    parameter int NUM_PORTS    = 2,
    parameter int SHIFT_WIDTH  = 24,
    parameter bit FILL_BIT     = 1'b0,
    parameter int TURBO_PERIOD = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             joypad_out,
    input  logic [NUM_PORTS-1:0]   joypad_clock,
    input  logic [31:0]            pad_buttons,
    input  logic                   four_score_en,
    input  logic [7:0]             turbo_mask,
    output logic [NUM_PORTS-1:0]   port_data,
    output logic [5*NUM_PORTS-1:0] read_count
);

    logic                   strobe;
    logic [NUM_PORTS-1:0]   jclk_prev_q;
    logic [NUM_PORTS-1:0]   fall;
    logic [31:0]            pads_eff;
    logic [SHIFT_WIDTH-1:0] load_word [NUM_PORTS];
    logic [SHIFT_WIDTH-1:0] shift_q   [NUM_PORTS];
    logic [SHIFT_WIDTH-1:0] shift_d   [NUM_PORTS];
    logic [4:0]             cnt_q     [NUM_PORTS];
    logic [4:0]             cnt_d     [NUM_PORTS];

    assign strobe = joypad_out[0];
    assign fall   = jclk_prev_q & ~joypad_clock;

`ifdef JOYPAD_TURBO_EN
    localparam int TW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

    logic [TW-1:0] turbo_cnt_q;
    logic          turbo_phase_q;
    logic          strobe_prev_q;
    logic          unused_bits;

    assign unused_bits = ^joypad_out[2:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
            strobe_prev_q <= 1'b0;
        end else begin
            strobe_prev_q <= strobe;
            if (strobe && !strobe_prev_q) begin
                if (turbo_cnt_q == TW'(TURBO_PERIOD - 1)) begin
                    turbo_cnt_q   <= '0;
                    turbo_phase_q <= ~turbo_phase_q;
                end else begin
                    turbo_cnt_q <= turbo_cnt_q + 1'b1;
                end
            end
        end
    end

    // Turbo-enabled A/B read as released during the low phase.
    always_comb begin
        pads_eff = pad_buttons;
        for (int n = 0; n < 4; n++) begin
            pads_eff[8*n +: 2] = pad_buttons[8*n +: 2] & ~(turbo_mask[2*n +: 2] & {2{~turbo_phase_q}});
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{joypad_out[2:1], turbo_mask};
    assign pads_eff    = pad_buttons;
`endif

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            load_word[p]      = '0;
            load_word[p][7:0] = pads_eff[8*p +: 8];
            if (four_score_en) begin
                if (NUM_PORTS == 2) begin
                    load_word[p][15:8] = pads_eff[8*(p+2) +: 8];
                end
                load_word[p][23:16] = (p == 0) ? 8'h08 : 8'h04;
            end
        end
    end

    // A read-clock edge wins over a simultaneous strobe reload.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            shift_d[p] = shift_q[p];
            cnt_d[p]   = cnt_q[p];
            if (fall[p]) begin
                shift_d[p] = {FILL_BIT, shift_q[p][SHIFT_WIDTH-1:1]};
                if (cnt_q[p] != 5'd31) begin
                    cnt_d[p] = cnt_q[p] + 5'd1;
                end
            end else if (strobe) begin
                shift_d[p] = load_word[p];
                cnt_d[p]   = 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            jclk_prev_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                shift_q[p] <= '0;
                cnt_q[p]   <= '0;
            end
        end else begin
            jclk_prev_q <= joypad_clock;
            for (int p = 0; p < NUM_PORTS; p++) begin
                shift_q[p] <= shift_d[p];
                cnt_q[p]   <= cnt_d[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_data[p]        = shift_q[p][0];
            read_count[5*p +: 5] = cnt_q[p];
        end
    end

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// Directed bench for nes_joypad_serializer (two ports, 24-bit shifters, TURBO_PERIOD=2).
// Turbo expectations follow whether JOYPAD_TURBO_EN is defined for the build.
module tb_nes_joypad_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] joypad_out;
    logic [1:0] joypad_clock;
    logic [31:0] pad_buttons;
    logic       four_score_en;
    logic [7:0] turbo_mask;
    logic [1:0] port_data;
    logic [9:0] read_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nes_joypad_serializer #(
        .NUM_PORTS   (2),
        .SHIFT_WIDTH (24),
        .FILL_BIT    (1'b0),
        .TURBO_PERIOD(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .joypad_out   (joypad_out),
        .joypad_clock (joypad_clock),
        .pad_buttons  (pad_buttons),
        .four_score_en(four_score_en),
        .turbo_mask   (turbo_mask),
        .port_data    (port_data),
        .read_count   (read_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        joypad_out   = 3'b000;
        joypad_clock = 2'b11;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic strobe_pulse();
        joypad_out = 3'b001;
        tick();
        joypad_out = 3'b000;
        tick();
    endtask

    task automatic fall_edge(input int p);
        joypad_clock[p] = 1'b0;
        tick();
        joypad_clock[p] = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (port_data !== 2'b00) begin
            errors++;
            $display("FAIL reset_port_data: got %b expected 00", port_data);
        end
        checks++;
        if (read_count !== 10'd0) begin
            errors++;
            $display("FAIL reset_read_count: got %h expected 000", read_count);
        end
    endtask

    task automatic test_basic();
        logic [7:0] w0;
        logic [7:0] w1;
        w0 = 8'h81;
        w1 = 8'h5A;
        pad_buttons = 32'h0000_5A81;
        strobe_pulse();
        checks++;
        if (read_count !== 10'd0) begin
            errors++;
            $display("FAIL basic_count_after_strobe: got %h expected 000", read_count);
        end
        // Pad changes with strobe low must not disturb the latched words.
        pad_buttons = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (port_data[0] !== w0[i]) begin
                errors++;
                $display("FAIL basic_p0_bit%0d: got %b expected %b", i, port_data[0], w0[i]);
            end
            fall_edge(0);
        end
        checks++;
        if (port_data[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_p0_fill: got %b expected 0", port_data[0]);
        end
        checks++;
        if (read_count[4:0] !== 5'd8) begin
            errors++;
            $display("FAIL basic_p0_count: got %0d expected 8", read_count[4:0]);
        end
        checks++;
        if (read_count[9:5] !== 5'd0) begin
            errors++;
            $display("FAIL basic_p1_count_idle: got %0d expected 0", read_count[9:5]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (port_data[1] !== w1[i]) begin
                errors++;
                $display("FAIL basic_p1_bit%0d: got %b expected %b", i, port_data[1], w1[i]);
            end
            fall_edge(1);
        end
        checks++;
        if (read_count[9:5] !== 5'd8) begin
            errors++;
            $display("FAIL basic_p1_count: got %0d expected 8", read_count[9:5]);
        end
        pad_buttons = 32'h0;
    endtask

    task automatic test_four_score();
        logic [23:0] w;
        do_reset();
        four_score_en = 1'b1;
        pad_buttons   = 32'h0;
        strobe_pulse();
        four_score_en = 1'b0;
        w = 24'h04_0000;
        for (int i = 0; i < 24; i++) begin
            if (i >= 16) begin
                checks++;
                if (port_data[1] !== w[i]) begin
                    errors++;
                    $display("FAIL fourscore_p1_sig_bit%0d: got %b expected %b", i, port_data[1], w[i]);
                end
            end
            fall_edge(1);
        end
        checks++;
        if (read_count[9:5] !== 5'd24) begin
            errors++;
            $display("FAIL fourscore_p1_count: got %0d expected 24", read_count[9:5]);
        end

        four_score_en = 1'b1;
        pad_buttons   = 32'h4433_2211;
        strobe_pulse();
        four_score_en = 1'b0;
        pad_buttons   = 32'h0;
        w = 24'h08_33_11;
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (port_data[0] !== w[i]) begin
                errors++;
                $display("FAIL fourscore_p0_bit%0d: got %b expected %b", i, port_data[0], w[i]);
            end
            fall_edge(0);
        end
        checks++;
        if (port_data[0] !== 1'b0) begin
            errors++;
            $display("FAIL fourscore_p0_fill: got %b expected 0", port_data[0]);
        end
    endtask

    task automatic test_collision();
        pad_buttons = 32'h0000_0081;
        strobe_pulse();
        checks++;
        if (port_data[0] !== 1'b1 || read_count[4:0] !== 5'd0) begin
            errors++;
            $display("FAIL collision_preload: got data=%b count=%0d expected data=1 count=0",
                     port_data[0], read_count[4:0]);
        end
        joypad_out      = 3'b001;
        joypad_clock[0] = 1'b0;
        tick();
        checks++;
        if (port_data[0] !== 1'b0 || read_count[4:0] !== 5'd1) begin
            errors++;
            $display("FAIL collision_shift_wins: got data=%b count=%0d expected data=0 count=1",
                     port_data[0], read_count[4:0]);
        end
        joypad_clock[0] = 1'b1;
        tick();
        checks++;
        if (port_data[0] !== 1'b1 || read_count[4:0] !== 5'd0) begin
            errors++;
            $display("FAIL collision_reload_next: got data=%b count=%0d expected data=1 count=0",
                     port_data[0], read_count[4:0]);
        end
        joypad_out = 3'b000;
        tick();
        pad_buttons = 32'h0;
    endtask

    task automatic test_saturate();
        pad_buttons = 32'h0000_00FF;
        strobe_pulse();
        pad_buttons = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            fall_edge(0);
            if (i == 7) begin
                checks++;
                if (port_data[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_bit7: got %b expected 1", port_data[0]);
                end
            end
            if (i == 8) begin
                checks++;
                if (port_data[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_bit8: got %b expected 0", port_data[0]);
                end
            end
            if (i == 31) begin
                checks++;
                if (read_count[4:0] !== 5'd31) begin
                    errors++;
                    $display("FAIL sat_count31: got %0d expected 31", read_count[4:0]);
                end
            end
        end
        checks++;
        if (read_count[4:0] !== 5'd31) begin
            errors++;
            $display("FAIL sat_count40: got %0d expected 31", read_count[4:0]);
        end
        checks++;
        if (port_data[0] !== 1'b0) begin
            errors++;
            $display("FAIL sat_fill: got %b expected 0", port_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        pad_buttons = 32'h0000_00FF;
        strobe_pulse();
        fall_edge(0);
        fall_edge(0);
        fall_edge(0);
        checks++;
        if (port_data[0] !== 1'b1 || read_count[4:0] !== 5'd3) begin
            errors++;
            $display("FAIL midreset_before: got data=%b count=%0d expected data=1 count=3",
                     port_data[0], read_count[4:0]);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (port_data !== 2'b00 || read_count !== 10'd0) begin
            errors++;
            $display("FAIL midreset_cleared: got data=%b count=%h expected data=00 count=000",
                     port_data, read_count);
        end
        reset = 1'b0;
        tick();
        pad_buttons = 32'h0000_0081;
        strobe_pulse();
        checks++;
        if (port_data[0] !== 1'b1 || read_count[4:0] !== 5'd0) begin
            errors++;
            $display("FAIL midreset_reload: got data=%b count=%0d expected data=1 count=0",
                     port_data[0], read_count[4:0]);
        end
        fall_edge(0);
        checks++;
        if (port_data[0] !== 1'b0 || read_count[4:0] !== 5'd1) begin
            errors++;
            $display("FAIL midreset_shift: got data=%b count=%0d expected data=0 count=1",
                     port_data[0], read_count[4:0]);
        end
        joypad_out = 3'b001;
        reset      = 1'b1;
        tick();
        checks++;
        if (port_data !== 2'b00 || read_count !== 10'd0) begin
            errors++;
            $display("FAIL reset_over_strobe: got data=%b count=%h expected data=00 count=000",
                     port_data, read_count);
        end
        reset      = 1'b0;
        joypad_out = 3'b000;
        tick();
        pad_buttons = 32'h0;
    endtask

    task automatic test_turbo();
        logic [5:0] seq;
`ifdef JOYPAD_TURBO_EN
        seq = 6'b001100;
`else
        seq = 6'b111111;
`endif
        do_reset();
        pad_buttons = 32'h0000_0001;
        turbo_mask  = 8'h01;
        for (int i = 0; i < 6; i++) begin
            strobe_pulse();
            checks++;
            if (port_data[0] !== seq[i]) begin
                errors++;
                $display("FAIL turbo_a_strobe%0d: got %b expected %b", i, port_data[0], seq[i]);
            end
        end
        turbo_mask  = 8'h00;
        pad_buttons = 32'h0;
    endtask

    initial begin
        reset         = 1'b1;
        joypad_out    = 3'b000;
        joypad_clock  = 2'b11;
        pad_buttons   = 32'h0;
        four_score_en = 1'b0;
        turbo_mask    = 8'h00;

        test_reset();
        test_basic();
        test_four_score();
        test_collision();
        test_saturate();
        test_reset_mid();
        test_turbo();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
